fetch_seq_ctrl: RTL

- Sequencer for the 10-bit instruction-address counter (ctr) that feeds instruction memory in the Harvard MIPS fetch path.
- Drives the counter's en/dir/jmp/jmpLoc controls from pipeline requests: boot, stall, branch, call/return and halt.
- Holds a small return-address stack and flags when fetched words are valid.

---
 rtl/fetch_seq_ctrl_if.sv | 32 +++
 rtl/fetch_seq_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_seq_ctrl_if.sv
// Control bundle between the fetch pipeline and the fetch sequencer.
// The sequencer sits on the slave side; the pipeline/counter side is the master.
interface fetch_seq_ctrl_if #(
  parameter int unsigned AW = 10
) ();
  logic [AW-1:0] ctr_out;
  logic          stall;
  logic          br_req;
  logic [AW-1:0] br_target;
  logic          call_req;
  logic          ret_req;
  logic          halt_req;
  logic          resume;
  logic          ctr_en;
  logic          ctr_dir;
  logic          ctr_jmp;
  logic [AW-1:0] ctr_jmp_loc;
  logic          fetch_valid;
  logic          ras_ovf;
  logic          ras_unf;
  logic          halted;

  modport master (
    output ctr_out, stall, br_req, br_target, call_req, ret_req, halt_req, resume,
    input  ctr_en, ctr_dir, ctr_jmp, ctr_jmp_loc, fetch_valid, ras_ovf, ras_unf, halted
  );

  modport slave (
    input  ctr_out, stall, br_req, br_target, call_req, ret_req, halt_req, resume,
    output ctr_en, ctr_dir, ctr_jmp, ctr_jmp_loc, fetch_valid, ras_ovf, ras_unf, halted
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch-address sequencer: drives the instruction-address counter from pipeline
// requests and keeps a small return-address stack for call/return.
module fetch_seq_ctrl #(
  parameter int unsigned   AW        = 10,
  parameter logic [AW-1:0] BOOT_ADDR = '0,
  parameter int unsigned   RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  fetch_seq_ctrl_if.slave  bus
);

  localparam int unsigned IdxW = $clog2(RAS_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  typedef enum logic [2:0] {
    StBoot,
    StRun,
    StRedirect,
    StStalled,
    StHalted
  } state_e;

  state_e          stateQ, stateD;
  logic [AW-1:0]   targetQ, targetD;
  logic [PtrW-1:0] ptrQ, ptrD;
  logic            ovfQ, ovfD;
  logic            unfQ, unfD;
  logic            pushEn;
  logic [AW-1:0]   rasMem [RAS_DEPTH];
  logic [PtrW-1:0] topPtr;
  logic [IdxW-1:0] topIdx;
  logic [IdxW-1:0] pushIdx;
  logic            rasEmpty;
  logic            rasFull;

  assign topPtr   = ptrQ - PtrW'(1);
  assign topIdx   = topPtr[IdxW-1:0];
  assign pushIdx  = ptrQ[IdxW-1:0];
  assign rasEmpty = (ptrQ == '0);
  assign rasFull  = (ptrQ == PtrW'(RAS_DEPTH));

  always_comb begin
    stateD  = stateQ;
    targetD = targetQ;
    ptrD    = ptrQ;
    ovfD    = ovfQ;
    unfD    = unfQ;
    pushEn  = 1'b0;
    unique case (stateQ)
      StBoot, StRedirect: stateD = StRun;
      StRun, StStalled: begin
        if (bus.halt_req) begin
          stateD = StHalted;
        end else if (bus.ret_req) begin
          if (rasEmpty) begin
            unfD   = 1'b1;
            stateD = StHalted;
          end else begin
            ptrD    = topPtr;
            targetD = rasMem[topIdx];
            stateD  = StRedirect;
          end
        end else if (bus.call_req) begin
          targetD = bus.br_target;
          stateD  = StRedirect;
          // A full stack drops the return address but the jump is still taken.
          if (rasFull) begin
            ovfD = 1'b1;
          end else begin
            pushEn = 1'b1;
            ptrD   = ptrQ + PtrW'(1);
          end
        end else if (bus.br_req) begin
          targetD = bus.br_target;
          stateD  = StRedirect;
        end else if (bus.stall) begin
          stateD = StStalled;
        end else begin
          stateD = StRun;
        end
      end
      StHalted: begin
        if (!bus.halt_req && bus.resume) stateD = StRun;
      end
      default: stateD = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= StBoot;
      targetQ <= BOOT_ADDR;
      ptrQ    <= '0;
      ovfQ    <= 1'b0;
      unfQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      targetQ <= targetD;
      ptrQ    <= ptrD;
      ovfQ    <= ovfD;
      unfQ    <= unfD;
    end
  end

  // Stack contents need no reset; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (pushEn) rasMem[pushIdx] <= bus.ctr_out + AW'(1);
  end

  always_comb begin
    bus.ctr_en      = 1'b0;
    bus.ctr_dir     = 1'b1;
    bus.ctr_jmp     = 1'b0;
    bus.ctr_jmp_loc = BOOT_ADDR;
    bus.fetch_valid = 1'b0;
    bus.halted      = 1'b0;
    unique case (stateQ)
      StBoot: begin
        bus.ctr_en  = 1'b1;
        bus.ctr_jmp = 1'b1;
      end
      StRedirect: begin
        bus.ctr_en      = 1'b1;
        bus.ctr_jmp     = 1'b1;
        bus.ctr_jmp_loc = targetQ;
      end
      StRun: begin
        bus.ctr_en      = 1'b1;
        bus.fetch_valid = 1'b1;
      end
      StHalted: bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.ras_ovf = ovfQ;
  assign bus.ras_unf = unfQ;

endmodule
